riscv_mmio_bus: RTL and testbench
=================================

// Module: riscv_mmio_bus
// PURPOSE
// - Parametrised data-side bus splitter between the RISC-V datapath and memory/peripherals.
// - Replaces the fixed one-bit RAM/IO split and zero-wait IO path with N_CH peripheral channels.
// - Each channel uses a req/ready handshake and the CPU is stalled until the access completes.
// - RAM accesses stay single-cycle and pass straight through.
// PARAMETERS
// - ADDR_W   32  CPU byte-address width
// - DATA_W   32  data width; mask width is DATA_W/8
// - N_CH     4   peripheral channel count (1..16)
// - IO_BIT   22  address bit selecting IO space (1) or RAM (0)
// - CH_LSB   12  channel index = addr[CH_LSB+3:CH_LSB]; offset = addr[CH_LSB-1:0]
// - TIMEOUT  15  max ACCESS cycles before abort (BUS_TIMEOUT_EN only)
// PORTS
// - clk         in   1             single clock, rising edge
// - reset       in   1             synchronous, active-high
// - cpu_addr    in   ADDR_W        data address from datapath
// - cpu_wdata   in   DATA_W        store data
// - cpu_wmask   in   DATA_W/8      byte-lane write mask
// - cpu_load    in   1             load instruction active
// - cpu_store   in   1             store instruction active
// - cpu_rdata   out  DATA_W        load data to datapath
// - cpu_stall   out  1             hold PC/regfile this cycle
// - ram_wmask   out  DATA_W/8      RAM write enables
// - ram_rdata   in   DATA_W        RAM read data
// - ch_req      out  N_CH          one-hot request, registered
// - ch_we       out  1             1 = write, registered
// - ch_addr     out  CH_LSB        channel offset, registered
// - ch_wdata    out  DATA_W        registered store data
// - ch_wmask    out  DATA_W/8      registered byte mask
// - ch_ready    in   N_CH          per-channel completion
// - ch_rdata    in   N_CH*DATA_W   channel k read data = [k*DATA_W +: DATA_W]
// - bus_err     out  1             one-cycle pulse on unmapped access or timeout
// BEHAVIOUR
// - Reset values: state=IDLE; ch_req, ch_we, ch_addr, ch_wdata, ch_wmask, rdata_q, bus_err and tmo_cnt = 0.
// - RAM path (IDLE, cpu_addr[IO_BIT]=0), combinational:
//   - cpu_rdata = ram_rdata; ram_wmask = cpu_store ? cpu_wmask : 0; cpu_stall = 0.
// - Any IO-path cycle: ram_wmask = 0.
// - FSM IDLE:
//   - io_go = (cpu_load|cpu_store) & cpu_addr[IO_BIT]; cpu_stall = io_go, combinational.
//   - Mapped io_go (index < N_CH): latch ch_we=cpu_store, ch_addr, ch_wdata, ch_wmask; set ch_req[index]; go ACCESS.
//   - Unmapped io_go: no request; rdata_q=0; bus_err=1 next cycle; go DONE.
// - FSM ACCESS:
//   - cpu_stall=1.
//   - On ch_ready[sel]: rdata_q = ch_rdata[sel] (zeroed for writes); ch_req=0; go DONE.
//   - ch_ready of non-selected channels is ignored.
// - FSM DONE:
//   - cpu_stall=0; cpu_rdata=rdata_q; bus_err cleared; unconditionally go IDLE.
//   - DONE never re-triggers io_go; the datapath retires in this cycle.
// - Latency: an IO access takes 2 + W cycles, where W = ACCESS cycles until ready (W>=1).
//   - Minimum is 3 cycles, of which 2 are stalled.
// - ch_ready in IDLE/DONE is ignored. The datapath holds cpu_* stable while cpu_stall=1.
// - reset mid-ACCESS: ch_req drops the next edge, state=IDLE, and the pending access is lost.
// - At most one request is ever outstanding; ch_req is always one-hot or zero.
// CONFIGURATION
// - BUS_TIMEOUT_EN defined:
//   - tmo_cnt counts ACCESS cycles. At tmo_cnt==TIMEOUT-1 without ready: abort, ch_req=0, rdata_q=all ones, bus_err=1, go DONE.
//   - ch_ready in the same cycle as expiry wins: normal completion, no error.
//   - tmo_cnt clears on entry to ACCESS.
// - BUS_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; bus_err only for unmapped.
// TESTING
// - RAM: sw to 0x0000_0010, mask 4'b1111 -> ram_wmask=4'hF the same cycle, stall 0; lw returns ram_rdata the same cycle.
// - IO write: sw 0x0040_1004 data 0xA5 -> ch_req=4'b0010, ch_addr=0x004, ch_we=1; ready after 3 cycles -> 4 stalled cycles, DONE, bus_err=0.
// - IO read: lw 0x0040_3000, ch_rdata[3]=0xDEAD_BEEF, ready at first ACCESS cycle -> stall 2 cycles, cpu_rdata=0xDEAD_BEEF in DONE.
// - Unmapped: lw 0x0040_7000 (N_CH=4) -> no ch_req, 1 stall cycle, cpu_rdata=0, bus_err pulse.
// - Timeout (EN, TIMEOUT=15): ready never -> req held 15 cycles, cpu_rdata=0xFFFF_FFFF, bus_err=1; ready on cycle 15 -> normal data.
// - Reset in ACCESS: reset high 1 cycle -> ch_req=0, stall=0, state IDLE; late ch_ready ignored.

Source files
------------

// File: rtl/riscv_mmio_bus_if.sv
// Peripheral channel bus between the MMIO splitter (master) and the peripherals (slave).
// ch_req is one-hot or zero; the selected channel answers with ch_ready plus its slice of ch_rdata.
interface riscv_mmio_bus_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32,
    parameter int CH_LSB = 12
);
    logic [N_CH-1:0]        ch_req;
    logic                   ch_we;
    logic [CH_LSB-1:0]      ch_addr;
    logic [DATA_W-1:0]      ch_wdata;
    logic [DATA_W/8-1:0]    ch_wmask;
    logic [N_CH-1:0]        ch_ready;
    logic [N_CH*DATA_W-1:0] ch_rdata;

    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata, ch_wmask,
        input  ch_ready, ch_rdata
    );

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata, ch_wmask,
        output ch_ready, ch_rdata
    );
endinterface

// File: rtl/riscv_mmio_bus.sv
// Data-side splitter: RAM pass-through plus N_CH req/ready peripheral channels (optional BUS_TIMEOUT_EN abort).
// Latency: RAM combinational; IO access 2+W cycles (W = ACCESS cycles until ch_ready, W>=1).
// Backpressure: cpu_stall holds the datapath from the IO issue cycle until the channel answers or aborts.
module riscv_mmio_bus #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int N_CH    = 4,
    parameter int IO_BIT  = 22,
    parameter int CH_LSB  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [DATA_W/8-1:0]   cpu_wmask,
    input  logic                  cpu_load,
    input  logic                  cpu_store,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_stall,
    output logic [DATA_W/8-1:0]   ram_wmask,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  bus_err,
    riscv_mmio_bus_if.master      ch
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   rdata_q;
    logic                bus_err_q;
    logic [3:0]          ch_idx;
    logic                io_go, mapped;
    logic                start_acc, finish_acc, unmapped_go, abort_acc;
    logic                ready_sel;
    logic [DATA_W-1:0]   rdata_sel;
    logic [N_CH-1:0]     req_onehot;
    logic                unused_addr;

    assign ch_idx      = cpu_addr[CH_LSB+3:CH_LSB];
    assign io_go       = (cpu_load | cpu_store) & cpu_addr[IO_BIT];
    assign mapped      = ({1'b0, ch_idx} < 5'(N_CH));
    assign bus_err     = bus_err_q;
    assign unused_addr = ^cpu_addr;

    // ch_req is registered one-hot, so it doubles as the channel select.
    always_comb begin
        req_onehot = '0;
        rdata_sel  = '0;
        for (int k = 0; k < N_CH; k++) begin
            req_onehot[k] = (ch_idx == 4'(k));
            if (ch.ch_req[k]) rdata_sel = rdata_sel | ch.ch_rdata[k*DATA_W +: DATA_W];
        end
        ready_sel = |(ch.ch_req & ch.ch_ready);
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || start_acc) tmo_cnt <= '0;
        else if (state_q == ACCESS) tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    logic tmo_hit;
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cpu_stall   = 1'b0;
        cpu_rdata   = rdata_q;
        ram_wmask   = '0;
        start_acc   = 1'b0;
        finish_acc  = 1'b0;
        unmapped_go = 1'b0;
        abort_acc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cpu_addr[IO_BIT]) begin
                    cpu_rdata = ram_rdata;
                    ram_wmask = cpu_store ? cpu_wmask : '0;
                end
                cpu_stall = io_go;
                if (io_go) begin
                    if (mapped) begin
                        start_acc = 1'b1;
                        state_d   = ACCESS;
                    end else begin
                        unmapped_go = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            ACCESS: begin
                cpu_stall = 1'b1;
                // A ready arriving in the expiry cycle still completes normally.
                if (ready_sel) begin
                    finish_acc = 1'b1;
                    state_d    = DONE;
                end else if (tmo_hit) begin
                    abort_acc = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch.ch_req   <= '0;
            ch.ch_we    <= 1'b0;
            ch.ch_addr  <= '0;
            ch.ch_wdata <= '0;
            ch.ch_wmask <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            bus_err_q <= unmapped_go | abort_acc;
            if (start_acc) begin
                ch.ch_req   <= req_onehot;
                ch.ch_we    <= cpu_store;
                ch.ch_addr  <= cpu_addr[CH_LSB-1:0];
                ch.ch_wdata <= cpu_wdata;
                ch.ch_wmask <= cpu_wmask;
            end
            if (finish_acc) begin
                ch.ch_req <= '0;
                rdata_q   <= ch.ch_we ? '0 : rdata_sel;
            end
            if (unmapped_go) rdata_q <= '0;
            if (abort_acc) begin
                ch.ch_req <= '0;
                rdata_q   <= '1;
            end
        end
    end
endmodule

// File: tb/tb_riscv_mmio_bus.sv
// Directed bench for riscv_mmio_bus: RAM vector table plus multi-cycle IO, unmapped, wait/timeout and reset sequences.
module tb_riscv_mmio_bus;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, ram_rdata;
    logic [3:0]  cpu_wmask, ram_wmask;
    logic        cpu_load, cpu_store, cpu_stall, bus_err;

    int checks = 0;
    int errors = 0;

    riscv_mmio_bus_if #(.N_CH(4), .DATA_W(32), .CH_LSB(12)) bus ();

    riscv_mmio_bus #(
        .ADDR_W(32), .DATA_W(32), .N_CH(4), .IO_BIT(22), .CH_LSB(12), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
        .cpu_load(cpu_load), .cpu_store(cpu_store),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ram_wmask(ram_wmask), .ram_rdata(ram_rdata),
        .bus_err(bus_err), .ch(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        load;
        logic        store;
        logic [31:0] ram_rd;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic        exp_stall;
        logic [3:0]  exp_wmask;
    } vec_t;

    typedef struct {
        bit          finished;
        int          stalls;
        logic [3:0]  req_or;
        logic [3:0]  wm_or;
        logic [11:0] addr_snap;
        logic        we_snap;
        logic [31:0] wd_snap;
        logic [3:0]  wm_snap;
        logic [31:0] done_rdata;
        logic        done_err;
        logic        post_err;
    } res_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_wmask = '0;
        cpu_load  = 1'b0;
        cpu_store = 1'b0;
        bus.ch_ready = '0;
    endtask

    // Runs one IO access; rdy_at = ACCESS cycle (1-based) on which the channel answers, 0 = never.
    task automatic io_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask,
                          input bit st, input int rdy_at, input int chn, input logic [31:0] rd,
                          input logic [3:0] noise, output res_t r);
        logic [31:0] fill;
        r = '{default: '0};
        @(posedge clk); #1;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wmask = mask;
        cpu_store = st;
        cpu_load  = !st;
        for (int k = 0; k < 4; k++) begin
            fill = 32'h1111_1111 * (k + 1);
            bus.ch_rdata[k*32 +: 32] = fill;
        end
        bus.ch_rdata[chn*32 +: 32] = rd;
        bus.ch_ready = noise;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            r.req_or = r.req_or | bus.ch_req;
            r.wm_or  = r.wm_or | ram_wmask;
            if (!cpu_stall) begin
                r.finished   = 1'b1;
                r.done_rdata = cpu_rdata;
                r.done_err   = bus_err;
                break;
            end
            r.stalls++;
            if (r.stalls == 2) begin
                r.addr_snap = bus.ch_addr;
                r.we_snap   = bus.ch_we;
                r.wd_snap   = bus.ch_wdata;
                r.wm_snap   = bus.ch_wmask;
            end
            @(posedge clk); #1;
            bus.ch_ready = (rdy_at == r.stalls) ? (noise | 4'(1 << chn)) : noise;
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        r.post_err = bus_err;
    endtask

    vec_t vecs[5];
    res_t r;

    initial begin
        vecs[0] = '{32'h0000_0010, 32'h0000_0001, 4'hF, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0, 4'hF};
        vecs[1] = '{32'h0000_0010, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0, 4'h0};
        vecs[2] = '{32'h0000_0013, 32'h4200_0000, 4'h8, 1'b0, 1'b1, 32'h0000_0042, 1'b1, 32'h0000_0042, 1'b0, 4'h8};
        vecs[3] = '{32'h003F_FFFC, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 32'h0BAD_CAFE, 1'b1, 32'h0BAD_CAFE, 1'b0, 4'h0};
        vecs[4] = '{32'h0040_1000, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 32'h5555_5555, 1'b0, 32'h0000_0000, 1'b0, 4'h0};

        idle_inputs();
        bus.ch_rdata = '0;
        ram_rdata    = '0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ch_req", bus.ch_req, 4'h0);
        chk("reset_ch_we", bus.ch_we, 1'b0);
        chk("reset_ch_addr", bus.ch_addr, 12'h0);
        chk("reset_ch_wdata", bus.ch_wdata, 32'h0);
        chk("reset_ch_wmask", bus.ch_wmask, 4'h0);
        chk("reset_bus_err", bus_err, 1'b0);
        chk("reset_stall", cpu_stall, 1'b0);

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wdata;
            cpu_wmask = vecs[i].wmask;
            cpu_load  = vecs[i].load;
            cpu_store = vecs[i].store;
            ram_rdata = vecs[i].ram_rd;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), cpu_stall, vecs[i].exp_stall);
            chk($sformatf("vec%0d_ram_wmask", i), ram_wmask, vecs[i].exp_wmask);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_no_req", i), bus.ch_req, 4'h0);
        end
        @(posedge clk); #1 idle_inputs();

        // IO write on channel 1, ready on third ACCESS cycle, channel 2 ready noise ignored.
        io_txn(32'h0040_1004, 32'h0000_00A5, 4'hF, 1'b1, 3, 1, 32'h7777_7777, 4'b0100, r);
        chk("wr_finished", r.finished, 1'b1);
        chk("wr_stalls", r.stalls, 4);
        chk("wr_req", r.req_or, 4'b0010);
        chk("wr_addr", r.addr_snap, 12'h004);
        chk("wr_we", r.we_snap, 1'b1);
        chk("wr_wdata", r.wd_snap, 32'h0000_00A5);
        chk("wr_wmask", r.wm_snap, 4'hF);
        chk("wr_ram_wmask", r.wm_or, 4'h0);
        chk("wr_rdata", r.done_rdata, 32'h0);
        chk("wr_err", r.done_err, 1'b0);

        // IO read channel 3, ready at first ACCESS cycle.
        io_txn(32'h0040_3000, 32'h0, 4'h0, 1'b0, 1, 3, 32'hDEAD_BEEF, 4'b0000, r);
        chk("rd_stalls", r.stalls, 2);
        chk("rd_req", r.req_or, 4'b1000);
        chk("rd_we", r.we_snap, 1'b0);
        chk("rd_addr", r.addr_snap, 12'h000);
        chk("rd_rdata", r.done_rdata, 32'hDEAD_BEEF);
        chk("rd_err", r.done_err, 1'b0);

        // Byte store to channel 0 at the top of its window.
        io_txn(32'h0040_0FFC, 32'h00CC_0000, 4'b0100, 1'b1, 2, 0, 32'h2468_ACE0, 4'b0000, r);
        chk("sb_stalls", r.stalls, 3);
        chk("sb_addr", r.addr_snap, 12'hFFC);
        chk("sb_wmask", r.wm_snap, 4'b0100);
        chk("sb_wdata", r.wd_snap, 32'h00CC_0000);

        // Unmapped channel 7: no request, one stall, error pulse.
        io_txn(32'h0040_7000, 32'h0, 4'h0, 1'b0, 0, 0, 32'h0, 4'b1111, r);
        chk("unm_stalls", r.stalls, 1);
        chk("unm_req", r.req_or, 4'b0000);
        chk("unm_rdata", r.done_rdata, 32'h0);
        chk("unm_err", r.done_err, 1'b1);
        chk("unm_err_pulse", r.post_err, 1'b0);

        // Ready exactly on the 15th ACCESS cycle completes normally in either build.
        io_txn(32'h0040_2008, 32'h0, 4'h0, 1'b0, 15, 2, 32'h0BAD_F00D, 4'b0000, r);
        chk("late_stalls", r.stalls, 16);
        chk("late_rdata", r.done_rdata, 32'h0BAD_F00D);
        chk("late_err", r.done_err, 1'b0);

        // Slow channel answering on the 25th ACCESS cycle.
        io_txn(32'h0040_0010, 32'h0, 4'h0, 1'b0, 25, 0, 32'h1357_9BDF, 4'b0000, r);
        chk("slow_req", r.req_or, 4'b0001);
`ifdef BUS_TIMEOUT_EN
        chk("tmo_stalls", r.stalls, 16);
        chk("tmo_rdata", r.done_rdata, 32'hFFFF_FFFF);
        chk("tmo_err", r.done_err, 1'b1);
        chk("tmo_err_pulse", r.post_err, 1'b0);
`else
        chk("wait_stalls", r.stalls, 26);
        chk("wait_rdata", r.done_rdata, 32'h1357_9BDF);
        chk("wait_err", r.done_err, 1'b0);
`endif

        // Reset during ACCESS drops the request; a late ready is ignored.
        @(posedge clk); #1;
        cpu_addr = 32'h0040_2000;
        cpu_load = 1'b1;
        @(negedge clk);
        chk("rst_issue_stall", cpu_stall, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_access_req", bus.ch_req, 4'b0100);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        bus.ch_ready = 4'b0100;
        @(negedge clk);
        chk("rst_req", bus.ch_req, 4'h0);
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_err", bus_err, 1'b0);
        @(posedge clk); #1;
        bus.ch_ready = '0;
        cpu_addr  = 32'h0000_0100;
        cpu_load  = 1'b1;
        ram_rdata = 32'hA1B2_C3D4;
        @(negedge clk);
        chk("rst_idle_rdata", cpu_rdata, 32'hA1B2_C3D4);
        chk("rst_idle_stall", cpu_stall, 1'b0);
        chk("rst_late_err", bus_err, 1'b0);
        @(posedge clk); #1 idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
